mod_inv: RTL

- Field inversion over GF(p), p = 2^255 - 19, using the binary extended Euclidean algorithm.
- Serves as the complement to mod_exp: it undoes multiplication, turning a projective X/Z result into affine X * Z^-1 at the end of a Montgomery ladder.
- Accepts one operand through a start/done handshake and iterates one step per clock.
- Output is result with a*result = 1 (mod p); a zero residue raises err instead.

---
 rtl/fe25519_pkg.sv | 36 +++
 rtl/mod_half.sv | 17 +
 rtl/mod_inv.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fe25519_pkg.sv
// Shared definitions for GF(2^255 - 19) arithmetic blocks (mod_exp, mod_inv).
//   N       : field element width in bits
//   P       : field prime 2^255 - 19, held at N+1 bits so it mixes with wide values
//   fe_t    : reduced field element, N bits
//   fe_w_t  : wide element, N+1 bits; holds x + p without overflow
//   state_e : inversion FSM states
package fe25519_pkg;

    localparam int unsigned N = 255;

    typedef logic [N-1:0] fe_t;
    typedef logic [N:0]   fe_w_t;

    localparam fe_w_t P   = (fe_w_t'(1) << N) - fe_w_t'(19);
    localparam fe_w_t One = fe_w_t'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIter,
        StFin,
        StDone
    } state_e;

    // Modular difference of two reduced values; never leaves the range 0 .. p-1.
    function automatic fe_w_t fe_sub(input fe_w_t x, input fe_w_t y);
        fe_w_t diff;
        if (x >= y) begin
            diff = x - y;
        end else begin
            diff = x + (P - y);
        end
        return diff;
    endfunction

endpackage

// File: rtl/mod_half.sv
// Modular halving in GF(p): returns x / 2 mod p for a reduced input x < p.
//   x_i    : reduced operand, N+1 bits (MSB is zero for reduced inputs)
//   half_o : x/2 if x is even, (x + p)/2 if x is odd; always < p
module mod_half
    import fe25519_pkg::*;
(
    input  logic [N:0] x_i,
    output logic [N:0] half_o
);

    fe_w_t sum;

    // x + p < 2p < 2^(N+1), so the sum never overflows the wide type.
    assign sum    = x_i + P;
    assign half_o = x_i[0] ? (sum >> 1) : (x_i >> 1);

endmodule

// File: rtl/mod_inv.sv
// Field inversion over GF(2^255 - 19) by the binary extended Euclidean algorithm.
// One algorithm step per clock; start/done handshake.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start_i  : request strobe, sampled only in idle
//   a_i      : operand, any N-bit value, captured on the accepted start cycle
//   busy_o   : high from the cycle after an accepted start until done
//   done_o   : one-cycle pulse; result_o/err_o valid then and held until next start
//   result_o : a^-1 mod p in 1 .. p-1; zero when err_o
//   err_o    : a mod p == 0, no inverse exists
module mod_inv
    import fe25519_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic         err_o
);

    state_e       state_q, state_d;
    fe_w_t        u_q, u_d;
    fe_w_t        v_q, v_d;
    fe_w_t        x1_q, x1_d;
    fe_w_t        x2_q, x2_d;
    logic [N-1:0] result_q, result_d;
    logic         err_q, err_d;

    fe_w_t x1_half, x2_half;
    fe_w_t u_red;
    fe_w_t x1_sub, x2_sub;

    mod_half u_half_x1 (
        .x_i    (x1_q),
        .half_o (x1_half)
    );

    mod_half u_half_x2 (
        .x_i    (x2_q),
        .half_o (x2_half)
    );

    // The raw operand is below 2^N < 2p, so one conditional subtraction reduces it.
    assign u_red  = (u_q >= P) ? (u_q - P) : u_q;
    assign x1_sub = fe_sub(x1_q, x2_q);
    assign x2_sub = fe_sub(x2_q, x1_q);

    always_comb begin
        state_d  = state_q;
        u_d      = u_q;
        v_d      = v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    u_d      = {1'b0, a_i};
                    v_d      = '0;
                    x1_d     = '0;
                    x2_d     = '0;
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = StLoad;
                end
            end

            StLoad: begin
                if (u_red == '0) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = StDone;
                end else begin
                    u_d     = u_red;
                    v_d     = P;
                    x1_d    = One;
                    x2_d    = '0;
                    state_d = StIter;
                end
            end

            // Invariants: x1 * a == u and x2 * a == v (mod p).
            StIter: begin
                if ((u_q == One) || (v_q == One)) begin
                    state_d = StFin;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = x1_sub;
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = x2_sub;
                end
            end

            // u wins a tie with v, so u == v == 1 returns x1.
            StFin: begin
                result_d = (u_q == One) ? x1_q[N-1:0] : x2_q[N-1:0];
                state_d  = StDone;
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            u_q      <= u_d;
            v_q      <= v_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy_o   = (state_q == StLoad) || (state_q == StIter) || (state_q == StFin);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;
    assign err_o    = err_q;

endmodule
